pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor for the datapath ALU. It splits a WIDTH-bit operation into SEG-bit segments and resolves one segment per pipeline stage, passing the carry forward through registers. This gives one result per cycle at a short per-stage carry path. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-read stage and a writeback stage that may stall.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of SEG.
- SEG, 16: segment width resolved per stage. STAGES = WIDTH/SEG, minimum 1.
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- in_x  input  WIDTH  operand x
- in_y  input  WIDTH  operand y
- in_cy  input  1  carry-in; used only when in_sub=0
- in_sub  input  1  0: x+y+in_cy; 1: x−y (x+~y+1, in_cy ignored)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- out_s  output  WIDTH  sum/difference, modulo 2^WIDTH
- out_cy  output  1  carry out of bit WIDTH−1; in sub mode, 1 = no borrow
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- out_zero  output  1  out_s == 0

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stage registers, including valid bits, load only when adv=1.
- A beat is accepted when in_valid && in_ready.
- Stage k (0..STAGES−1) computes segment k: s[k*SEG +: SEG] = x_seg + y_eff_seg + c_k.
  - y_eff = in_sub ? ~in_y : in_y, computed at entry.
  - c_0 = in_sub ? 1 : in_cy.
  - c_k (k>0) is the registered carry out of stage k−1.
- Operand skew: segment k's x and y_eff bits are carried in registers until stage k consumes them. Completed lower segments are carried in registers alongside.
- Zero detection is accumulated per segment: z_k = z_{k−1} && (segment k == 0).
- Overflow is formed in the last stage from the carry into and out of the MSB.
- Each stage holds a valid bit. Bubbles propagate and are not compressed. A stall freezes the whole pipe.
- Reset (rst_n=0, asynchronous): all valid bits and all data, carry and flag registers clear to 0.
  - Outputs after reset: out_valid=0, out_s=0, out_cy=0, out_ovf=0, out_zero=0, in_ready=1.
  - Reset mid-operation discards all in-flight beats. No output beat appears for them after reset release.

## Timing
- Latency: a beat accepted at edge N is presented on out_* with out_valid=1 after edge N+STAGES−1. For STAGES=1 it appears right after the accepting edge.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: if out_valid=1 and out_ready=0, in_ready=0 combinationally in the same cycle. out_* and every stage hold stable until out_ready=1.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- Simultaneous transfer: when out_valid && out_ready && in_valid, the output beat retires and a new beat enters on the same edge.
- While out_valid=0, out_* data values are don't-care to consumers but must equal the last registered contents. They are never X after reset.
- Parameter misuse (WIDTH % SEG ≠ 0) is a fatal elaboration error.

## Test plan
All scenarios use WIDTH=32, SEG=16, out_ready=1 unless stated.
- Carry across the segment boundary: x=0x0000FFFF, y=0x00000001, cy=0, add → out_s=0x00010000, cy=0, ovf=0, zero=0. out_valid appears 2 edges after acceptance.
- Signed overflow and wrap:
  - 0x7FFFFFFF+0x00000001 → 0x80000000, ovf=1, cy=0.
  - 0xFFFFFFFF+0xFFFFFFFF with cy=1 → 0xFFFFFFFF, cy=1, ovf=0.
  - 0xFFFFFFFF+0x00000001 → 0x00000000, cy=1, zero=1.
- Subtract:
  - 5−7 → 0xFFFFFFFE, cy=0, ovf=0.
  - 0x80000000−1 → 0x7FFFFFFF, cy=1, ovf=1.
  - 9−9 with in_cy=1 → 0, zero=1, cy=1. This confirms in_cy is ignored in sub mode.
- Backpressure: stream 4 back-to-back beats 1+1, 2+2, 3+3, 4+4. Hold out_ready=0 for 3 cycles once out_valid rises.
  - Required: in_ready=0 while stalled and out_s held at 2.
  - After release: 2, 4, 6, 8 delivered in order, with no loss or duplication.
- Reset mid-flight: accept 2 beats, then pulse rst_n low for a partial cycle between edges.
  - Required: out_valid=0, out_s=0 and in_ready=1 immediately.
  - Neither beat emerges afterward. The next beat 0x10+0x20 returns 0x30 with normal latency.
- Single-stage build (WIDTH=16, SEG=16): 0xFFFF+1 → 0x0000, cy=1, zero=1, latency 1 edge. Full throughput with toggling out_ready matches the reference model.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The slave side is the adder; the master side is whoever feeds it and drains it.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_cy;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_cy;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_x, in_y, in_cy, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_cy, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_x, in_y, in_cy, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_cy, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented add/sub pipeline: one SEG-bit slice per stage, carry rippling
// through registers, so the per-stage carry chain is only SEG bits long.
module pipelined_addsub_stage #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  input  logic             z_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             z_o,
  output logic             ovf_o
);
  logic [SEG:0]     sum;
  logic [WIDTH-1:0] s_nxt;
  logic             c_msb;

  assign sum   = {1'b0, x_i[SEG-1:0]} + {1'b0, y_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
  // Carry into the segment MSB, recovered from the MSB sum bit.
  assign c_msb = x_i[SEG-1] ^ y_i[SEG-1] ^ sum[SEG-1];

  // Operands shift down so the next stage always consumes the low slice;
  // the result shifts in from the top and lands aligned after the last stage.
  generate
    if (WIDTH > SEG) begin : g_multi
      assign s_nxt = {sum[SEG-1:0], s_i[WIDTH-1:SEG]};
    end else begin : g_single
      assign s_nxt = sum[SEG-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      s_o   <= '0;
      c_o   <= 1'b0;
      z_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (adv) begin
      vld_o <= vld_i;
      x_o   <= x_i >> SEG;
      y_o   <= y_i >> SEG;
      s_o   <= s_nxt;
      c_o   <= sum[SEG];
      z_o   <= z_i && (sum[SEG-1:0] == '0);
      ovf_o <= c_msb ^ sum[SEG];
    end
  end
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  generate
    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
      $fatal(1, "pipelined_addsub: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
    end
  endgenerate

  logic                         adv;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][WIDTH-1:0]   x_b, y_b, s_b;
  logic [STAGES:0]              c_b, z_b, o_b;

  // One global advance: a stalled output freezes every stage, bubbles included.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign vld_pipe[0] = bus.in_valid;
  assign x_b[0]      = bus.in_x;
  assign y_b[0]      = bus.in_sub ? ~bus.in_y : bus.in_y;
  assign s_b[0]      = '0;
  assign c_b[0]      = bus.in_sub ? 1'b1 : bus.in_cy;
  assign z_b[0]      = 1'b1;
  assign o_b[0]      = 1'b0;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipelined_addsub_stage #(.WIDTH(WIDTH), .SEG(SEG)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .vld_i (vld_pipe[k]),
        .x_i   (x_b[k]),
        .y_i   (y_b[k]),
        .s_i   (s_b[k]),
        .c_i   (c_b[k]),
        .z_i   (z_b[k]),
        .vld_o (vld_pipe[k+1]),
        .x_o   (x_b[k+1]),
        .y_o   (y_b[k+1]),
        .s_o   (s_b[k+1]),
        .c_o   (c_b[k+1]),
        .z_o   (z_b[k+1]),
        .ovf_o (o_b[k+1])
      );
    end
  endgenerate

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_s     = s_b[STAGES];
  assign bus.out_cy    = c_b[STAGES];
  assign bus.out_ovf   = o_b[STAGES];
  assign bus.out_zero  = z_b[STAGES];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a two-stage 32-bit build and a single-stage 16-bit build,
// directed corner vectors plus a randomized stream scored against an arithmetic model.
module tb_pipelined_addsub;
  typedef struct packed {
    logic [31:0] s;
    logic        cy;
    logic        ovf;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(32)) bus32 ();
  pipelined_addsub_if #(.WIDTH(16)) bus16 ();

  pipelined_addsub #(.WIDTH(32), .SEG(16)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  pipelined_addsub #(.WIDTH(16), .SEG(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic res_t model(int w, logic [31:0] x, logic [31:0] y, bit cy, bit sub);
    longint unsigned m, ux, uy, ur;
    longint          half, sx, sy, sr;
    res_t            r;
    m    = 64'd1 << w;
    half = longint'(m >> 1);
    ux   = {32'd0, x};
    uy   = {32'd0, y};
    sx   = (longint'(ux) >= half) ? longint'(ux) - longint'(m) : longint'(ux);
    sy   = (longint'(uy) >= half) ? longint'(uy) - longint'(m) : longint'(uy);
    if (sub) begin
      ur   = ux + m - uy;
      r.cy = (ux >= uy);
      sr   = sx - sy;
    end else begin
      ur   = ux + uy + (cy ? 64'd1 : 64'd0);
      r.cy = (ur >= m);
      sr   = sx + sy + (cy ? 64'sd1 : 64'sd0);
    end
    ur    = ur % m;
    r.s   = ur[31:0];
    r.ovf = (sr < -half) || (sr >= half);
    r.z   = (ur == 0);
    return r;
  endfunction

  task automatic drive(bit sel, bit v, logic [31:0] x, logic [31:0] y, bit cy, bit sub, bit rdy);
    if (sel) begin
      bus16.in_valid = v;  bus16.in_x = x[15:0]; bus16.in_y = y[15:0];
      bus16.in_cy = cy;    bus16.in_sub = sub;   bus16.out_ready = rdy;
    end else begin
      bus32.in_valid = v;  bus32.in_x = x;       bus32.in_y = y;
      bus32.in_cy = cy;    bus32.in_sub = sub;   bus32.out_ready = rdy;
    end
  endtask

  task automatic sample(bit sel, output logic ov, output logic ir, output res_t o);
    if (sel) begin
      ov = bus16.out_valid; ir = bus16.in_ready;
      o  = {16'd0, bus16.out_s, bus16.out_cy, bus16.out_ovf, bus16.out_zero};
    end else begin
      ov = bus32.out_valid; ir = bus32.in_ready;
      o  = {bus32.out_s, bus32.out_cy, bus32.out_ovf, bus32.out_zero};
    end
  endtask

  // Single beat with out_ready=1; checks acceptance, latency and all result fields.
  task automatic run_vec(bit sel, logic [31:0] x, logic [31:0] y, bit cy, bit sub,
                         logic [31:0] es, bit ecy, bit eovf, bit ez, string tag, int lat);
    logic ov, ir;
    res_t o;
    @(negedge clk);
    drive(sel, 1, x, y, cy, sub, 1);
    #1 sample(sel, ov, ir, o);
    chk({tag, "_in_ready"}, ir, 1);
    @(negedge clk);
    drive(sel, 0, x, y, cy, sub, 1);
    for (int i = 1; i < lat; i++) begin
      #1 sample(sel, ov, ir, o);
      chk({tag, "_early"}, ov, 0);
      @(negedge clk);
    end
    #1 sample(sel, ov, ir, o);
    chk({tag, "_valid"}, ov, 1);
    chk({tag, "_s"}, o.s, es);
    chk({tag, "_cy"}, o.cy, ecy);
    chk({tag, "_ovf"}, o.ovf, eovf);
    chk({tag, "_zero"}, o.z, ez);
  endtask

  // Random traffic with toggling out_ready; results scored in order against the model.
  task automatic stream(bit sel, int n);
    res_t        expq[$];
    res_t        e, o;
    logic        ov, ir;
    bit          v, rdy, cy, sub, feed;
    logic [31:0] x, y;
    int          w;
    w = sel ? 16 : 32;
    for (int c = 0; c < n + 60; c++) begin
      @(negedge clk);
      feed = (c < n);
      v    = feed && ($urandom_range(0, 3) != 0);
      rdy  = !feed || ($urandom_range(0, 2) != 0);
      x    = $urandom;  y = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      if (sel) begin x = x & 32'hFFFF; y = y & 32'hFFFF; end
      cy   = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      drive(sel, v, x, y, cy, sub, rdy);
      #1 sample(sel, ov, ir, o);
      chk(sel ? "w16_in_ready" : "w32_in_ready", ir, !ov || rdy);
      if (ov && rdy) begin
        chk(sel ? "w16_expected_beat" : "w32_expected_beat", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk(sel ? "w16_stream_result" : "w32_stream_result", o, e);
        end
      end
      if (v && ir) expq.push_back(model(w, x, y, cy, sub));
      if (!feed && expq.size() == 0) break;
    end
    chk(sel ? "w16_drained" : "w32_drained", expq.size(), 0);
    @(negedge clk);
    drive(sel, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic        ov, ir;
    res_t        o;
    logic [31:0] got[$];
    logic [31:0] pend[$];
    bit          acc;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(1'(sel), ov, ir, o);
      chk("rst_out_valid", ov, 0);
      chk("rst_in_ready", ir, 1);
      chk("rst_out_fields", o, '0);
    end
    rst_n = 1'b1;

    run_vec(0, 32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0, 0, "seg_carry", 2);
    run_vec(0, 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0, "pos_ovf", 2);
    run_vec(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, "all_ones_cy", 2);
    run_vec(0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1, "wrap_zero", 2);
    run_vec(0, 32'd5,        32'd7,        0, 1, 32'hFFFFFFFE, 0, 0, 0, "sub_borrow", 2);
    run_vec(0, 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0, "sub_ovf", 2);
    run_vec(0, 32'd9,        32'd9,        1, 1, 32'h00000000, 1, 0, 1, "sub_cy_ignored", 2);

    // Backpressure: four beats, output stalled 3 cycles once the first result shows.
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 1, 2, 2, 0, 0, 1);
    @(negedge clk);
    #1 sample(0, ov, ir, o);
    chk("bp_first_valid", ov, 1);
    drive(0, 1, 3, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 sample(0, ov, ir, o);
      chk("bp_in_ready_low", ir, 0);
      chk("bp_out_held", o.s, 32'd2);
      chk("bp_valid_held", ov, 1);
      @(negedge clk);
    end
    pend = '{32'd3, 32'd4};
    got.delete();
    drive(0, 1, 3, 3, 0, 0, 1);
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      #1 sample(0, ov, ir, o);
      if (ov) got.push_back(o.s);
      acc = bus32.in_valid && ir;
      @(negedge clk);
      if (acc) void'(pend.pop_front());
      if (pend.size() > 0) drive(0, 1, pend[0], pend[0], 0, 0, 1);
      else                 drive(0, 0, 0, 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_order_%0d", i), got[i], 32'(2 * (i + 1)));

    // Reset between edges with two beats in flight.
    @(negedge clk);
    drive(0, 1, 32'h111, 32'h1, 0, 0, 1);
    @(negedge clk);
    drive(0, 1, 32'h222, 32'h2, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1 sample(0, ov, ir, o);
    chk("midrst_out_valid", ov, 0);
    chk("midrst_out_s", o.s, 32'd0);
    chk("midrst_in_ready", ir, 1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 sample(0, ov, ir, o);
      chk("midrst_no_ghost", ov, 0);
    end
    run_vec(0, 32'h10, 32'h20, 0, 0, 32'h30, 0, 0, 0, "post_rst", 2);

    run_vec(1, 32'hFFFF, 32'h0001, 0, 0, 32'h0000, 1, 0, 1, "w16_wrap", 1);
    run_vec(1, 32'h7FFF, 32'h0001, 0, 0, 32'h8000, 0, 1, 0, "w16_ovf", 1);

    stream(0, 300);
    stream(1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
